// File: rtl/pll_mode_pkg.sv
// Shared types, video mode table and divider encoders for the video PLL mode controller.
package pll_mode_pkg;

   localparam int unsigned DIV_W          = 6;
   localparam int unsigned ODIV_W         = 8;
   localparam int unsigned MODE_TABLE_LEN = 4;
   localparam int unsigned TABLE_IDX_W    = 2;
   localparam int unsigned LOOKUP_W       = 8;

   typedef struct packed {
      logic [DIV_W-1:0]  idiv_sel;
      logic [DIV_W-1:0]  fbdiv_sel;
      logic [ODIV_W-1:0] odiv;
   } mode_entry_t;

   typedef struct packed {
      logic [DIV_W-1:0] idsel;
      logic [DIV_W-1:0] fbdsel;
      logic [DIV_W-1:0] odsel;
   } div_codes_t;

   typedef enum logic [1:0] {
      RST_HOLD  = 2'd0,
      WAIT_LOCK = 2'd1,
      READY     = 2'd2,
      FAIL      = 2'd3
   } pll_state_t;

   // VGA 126 MHz, 720p 371.25 MHz, 480p 135 MHz, 1080p30 371.25 MHz (27 MHz reference)
   localparam mode_entry_t MODE_TABLE [MODE_TABLE_LEN] = '{
      '{6'd2, 6'd13, 8'd4},
      '{6'd3, 6'd54, 8'd2},
      '{6'd0, 6'd4,  8'd4},
      '{6'd3, 6'd54, 8'd2}
   };

   function automatic logic [DIV_W-1:0] enc_idsel(input mode_entry_t e);
      return ~e.idiv_sel;
   endfunction

   function automatic logic [DIV_W-1:0] enc_fbdsel(input mode_entry_t e);
      return ~e.fbdiv_sel;
   endfunction

   // PLL expects the output divider as ~(ODIV/2 - 1)
   function automatic logic [DIV_W-1:0] enc_odsel(input mode_entry_t e);
      return ~(DIV_W'(e.odiv >> 1) - DIV_W'(1));
   endfunction

   function automatic mode_entry_t mode_lookup(input logic [LOOKUP_W-1:0] idx);
      mode_entry_t e;
      e = MODE_TABLE[0];
      if (32'(idx) < MODE_TABLE_LEN) e = MODE_TABLE[idx[TABLE_IDX_W-1:0]];
      return e;
   endfunction

   function automatic div_codes_t encode_mode(input logic [LOOKUP_W-1:0] idx);
      div_codes_t  c;
      mode_entry_t e;
      e        = mode_lookup(idx);
      c.idsel  = enc_idsel(e);
      c.fbdsel = enc_fbdsel(e);
      c.odsel  = enc_odsel(e);
      return c;
   endfunction

endpackage

// File: rtl/pll_mode_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the crystal clock domain.
module sync_2ff (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_mode_ctrl.sv
// Video PLL runtime controller: applies table modes to the dynamic dividers, sequences
// PLL reset, qualifies lock with retries, and gates the pixel/TMDS domain reset.
module pll_mode_ctrl
   import pll_mode_pkg::*;
#(
   parameter int unsigned NUM_MODES    = 4,
   parameter int unsigned MODE_W       = 2,
   parameter int unsigned BOOT_MODE    = 1,
   parameter int unsigned RESET_CYCLES = 16,
   parameter int unsigned LOCK_STABLE  = 1024,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned MAX_RETRIES  = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [MODE_W-1:0] mode_req,
   input  logic              mode_req_valid,
   output logic              mode_req_ready,
   input  logic              pll_lock,
   output logic              pll_reset,
   output logic [DIV_W-1:0]  pll_idsel,
   output logic [DIV_W-1:0]  pll_fbdsel,
   output logic [DIV_W-1:0]  pll_odsel,
   output logic              pixel_rstn,
   output logic [MODE_W-1:0] cur_mode,
   output logic              ready,
   output logic              error,
   output logic              bad_mode
);

   localparam int unsigned RST_W    = $clog2(RESET_CYCLES + 1);
   localparam int unsigned STABLE_W = $clog2(LOCK_STABLE + 1);
   localparam int unsigned TO_W     = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned RETRY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam div_codes_t  BOOT_CODES = encode_mode(LOOKUP_W'(BOOT_MODE));

   pll_state_t          state, state_d;
   logic [RST_W-1:0]    rst_cnt, rst_cnt_d;
   logic [STABLE_W-1:0] stable_cnt, stable_cnt_d;
   logic [TO_W-1:0]     timeout_cnt, timeout_cnt_d;
   logic [RETRY_W-1:0]  retries, retries_d;
   logic [MODE_W-1:0]   cur_mode_d;
   div_codes_t          codes, codes_d;

   logic lock_s;
   logic accept, mode_ok, same_mode;
   logic pll_reset_d, pixel_rstn_d, ready_d, error_d, bad_mode_d, mode_req_ready_d;

   sync_2ff u_lock_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (pll_lock),
      .q      (lock_s)
   );

   assign accept    = mode_req_valid && mode_req_ready;
   assign mode_ok   = 32'(mode_req) < NUM_MODES;
   assign same_mode = (state == READY) && (mode_req == cur_mode);

   assign pll_idsel  = codes.idsel;
   assign pll_fbdsel = codes.fbdsel;
   assign pll_odsel  = codes.odsel;

   // State, counters, mode/divider registers and registered outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state          <= RST_HOLD;
         rst_cnt        <= '0;
         stable_cnt     <= '0;
         timeout_cnt    <= '0;
         retries        <= '0;
         cur_mode       <= MODE_W'(BOOT_MODE);
         codes          <= BOOT_CODES;
         pll_reset      <= 1'b1;
         pixel_rstn     <= 1'b0;
         ready          <= 1'b0;
         error          <= 1'b0;
         bad_mode       <= 1'b0;
         mode_req_ready <= 1'b0;
      end else begin
         state          <= state_d;
         rst_cnt        <= rst_cnt_d;
         stable_cnt     <= stable_cnt_d;
         timeout_cnt    <= timeout_cnt_d;
         retries        <= retries_d;
         cur_mode       <= cur_mode_d;
         codes          <= codes_d;
         pll_reset      <= pll_reset_d;
         pixel_rstn     <= pixel_rstn_d;
         ready          <= ready_d;
         error          <= error_d;
         bad_mode       <= bad_mode_d;
         mode_req_ready <= mode_req_ready_d;
      end
   end

   // Next-state: reset hold, lock qualification with retry, and mode acceptance
   always_comb begin
      state_d       = state;
      rst_cnt_d     = rst_cnt;
      stable_cnt_d  = stable_cnt;
      timeout_cnt_d = timeout_cnt;
      retries_d     = retries;
      cur_mode_d    = cur_mode;
      codes_d       = codes;

      unique case (state)
         RST_HOLD: begin
            if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
               state_d       = WAIT_LOCK;
               rst_cnt_d     = '0;
               stable_cnt_d  = '0;
               timeout_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt + RST_W'(1);
            end
         end
         WAIT_LOCK: begin
            stable_cnt_d  = lock_s ? stable_cnt + STABLE_W'(1) : '0;
            timeout_cnt_d = timeout_cnt + TO_W'(1);
            if (lock_s && (stable_cnt == STABLE_W'(LOCK_STABLE - 1))) begin
               state_d = READY;
            end else if (timeout_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
               if (retries < RETRY_W'(MAX_RETRIES)) begin
                  retries_d = retries + RETRY_W'(1);
                  rst_cnt_d = '0;
                  state_d   = RST_HOLD;
               end else begin
                  state_d = FAIL;
               end
            end
         end
         READY: begin
            // Lost lock: requalify without pulsing the PLL reset
            if (!lock_s) begin
               state_d       = WAIT_LOCK;
               stable_cnt_d  = '0;
               timeout_cnt_d = '0;
               retries_d     = '0;
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
      endcase

      // A new in-range mode overrides anything above, including a lock drop
      if (accept && mode_ok && !same_mode) begin
         codes_d    = encode_mode(LOOKUP_W'(mode_req));
         cur_mode_d = mode_req;
         retries_d  = '0;
         rst_cnt_d  = '0;
         state_d    = RST_HOLD;
      end
   end

   // Output decode from the next state so every output is a flop aligned with state
   always_comb begin
      pll_reset_d      = 1'b0;
      pixel_rstn_d     = 1'b0;
      ready_d          = 1'b0;
      error_d          = 1'b0;
      mode_req_ready_d = 1'b0;
      bad_mode_d       = accept && !mode_ok;

      unique case (state_d)
         RST_HOLD:  pll_reset_d = 1'b1;
         WAIT_LOCK: pll_reset_d = 1'b0;
         READY: begin
            ready_d          = 1'b1;
            pixel_rstn_d     = 1'b1;
            mode_req_ready_d = 1'b1;
         end
         FAIL: begin
            error_d          = 1'b1;
            mode_req_ready_d = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// Self-checking bench for pll_mode_ctrl with a behavioural PLL lock model.
module tb_pll_mode_ctrl;

   localparam int unsigned NUM_MODES    = 3;
   localparam int unsigned BOOT_MODE    = 1;
   localparam int unsigned RESET_CYCLES = 16;
   localparam int unsigned LOCK_STABLE  = 1024;
   localparam int unsigned LOCK_TIMEOUT = 2000;
   localparam int unsigned MAX_RETRIES  = 3;
   localparam int LIMIT     = 20000;
   localparam int READY_LAT = 2 + LOCK_STABLE;

   localparam int IDIV  [4] = '{2, 3, 0, 3};
   localparam int FBDIV [4] = '{13, 54, 4, 54};
   localparam int ODIV  [4] = '{4, 2, 4, 2};

   logic       clk = 1'b0;
   logic       resetn;
   logic [1:0] mode_req;
   logic       mode_req_valid;
   logic       mode_req_ready;
   logic       pll_lock;
   logic       pll_reset;
   logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
   logic       pixel_rstn;
   logic [1:0] cur_mode;
   logic       ready, error, bad_mode;

   int n_checks = 0;
   int n_fail   = 0;
   int model_mode;

   always #5 clk = ~clk;

   pll_mode_ctrl #(
      .NUM_MODES    (NUM_MODES),
      .MODE_W       (2),
      .BOOT_MODE    (BOOT_MODE),
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_STABLE  (LOCK_STABLE),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .MAX_RETRIES  (MAX_RETRIES)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .mode_req       (mode_req),
      .mode_req_valid (mode_req_valid),
      .mode_req_ready (mode_req_ready),
      .pll_lock       (pll_lock),
      .pll_reset      (pll_reset),
      .pll_idsel      (pll_idsel),
      .pll_fbdsel     (pll_fbdsel),
      .pll_odsel      (pll_odsel),
      .pixel_rstn     (pixel_rstn),
      .cur_mode       (cur_mode),
      .ready          (ready),
      .error          (error),
      .bad_mode       (bad_mode)
   );

   // 6-bit one's complement written as 63 - x
   function automatic logic [17:0] exp_codes(input int m);
      int i, f, o;
      i = 63 - IDIV[m];
      f = 63 - FBDIV[m];
      o = 63 - (ODIV[m] / 2 - 1);
      return {6'(i), 6'(f), 6'(o)};
   endfunction

   task automatic send_req(input logic [1:0] m, output bit ok);
      int waited;
      waited = 0;
      mode_req = m;
      mode_req_valid = 1'b1;
      while (!mode_req_ready && waited < LIMIT) begin
         @(negedge clk);
         waited++;
      end
      ok = mode_req_ready;
      @(negedge clk);
      mode_req_valid = 1'b0;
   endtask

   task automatic rst_width(output int w);
      w = 0;
      while (pll_reset && w < LIMIT) begin
         w++;
         @(negedge clk);
      end
   endtask

   task automatic lock_after(input int delay, output int lat);
      repeat (delay) @(negedge clk);
      pll_lock = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ready && lat < LIMIT);
   endtask

   task automatic test_reset();
      int w, lat;
      resetn = 1'b0; mode_req_valid = 1'b0; mode_req = 2'd0; pll_lock = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({pll_reset, pixel_rstn, ready, error, bad_mode, mode_req_ready} !== 6'b100000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 100000",
            {pll_reset, pixel_rstn, ready, error, bad_mode, mode_req_ready});
      end
      n_checks++;
      if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'h3C, 6'h09, 6'h3F}) begin
         n_fail++; $display("FAIL reset_dividers: got %h/%h/%h want 3c/09/3f", pll_idsel, pll_fbdsel, pll_odsel);
      end
      n_checks++;
      if (cur_mode !== 2'(BOOT_MODE)) begin
         n_fail++; $display("FAIL reset_cur_mode: got %0d want %0d", cur_mode, BOOT_MODE);
      end
      resetn = 1'b1;
      rst_width(w);
      n_checks++;
      if (w != int'(RESET_CYCLES)) begin
         n_fail++; $display("FAIL boot_rst_width: got %0d want %0d", w, RESET_CYCLES);
      end
      lock_after(100, lat);
      n_checks++;
      if (lat != READY_LAT) begin
         n_fail++; $display("FAIL boot_ready_latency: got %0d want %0d", lat, READY_LAT);
      end
      n_checks++;
      if ({ready, pixel_rstn, mode_req_ready, pll_reset, error} !== 5'b11100) begin
         n_fail++; $display("FAIL boot_ready_flags: got %b want 11100",
            {ready, pixel_rstn, mode_req_ready, pll_reset, error});
      end
      model_mode = int'(BOOT_MODE);
   endtask

   task automatic test_mode_change();
      bit ok;
      int w, lat;
      send_req(2'd0, ok);
      pll_lock = 1'b0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL chg_accept: got not-accepted want accepted"); end
      n_checks++;
      if ({pll_reset, ready, pixel_rstn, mode_req_ready} !== 4'b1000) begin
         n_fail++; $display("FAIL chg_n1_flags: got %b want 1000", {pll_reset, ready, pixel_rstn, mode_req_ready});
      end
      n_checks++;
      if ({pll_idsel, pll_fbdsel, pll_odsel} !== exp_codes(0) || cur_mode !== 2'd0) begin
         n_fail++; $display("FAIL chg_dividers: got %h/%h/%h mode %0d want %h mode 0",
            pll_idsel, pll_fbdsel, pll_odsel, cur_mode, exp_codes(0));
      end
      rst_width(w);
      n_checks++;
      if (w != int'(RESET_CYCLES)) begin
         n_fail++; $display("FAIL chg_rst_width: got %0d want %0d", w, RESET_CYCLES);
      end
      lock_after(int'($urandom_range(20, 300)), lat);
      n_checks++;
      if (lat != READY_LAT || pixel_rstn !== 1'b1) begin
         n_fail++; $display("FAIL chg_ready_latency: got %0d rstn %b want %0d rstn 1", lat, pixel_rstn, READY_LAT);
      end
      model_mode = 0;
   endtask

   task automatic test_fail_recover();
      bit ok, prev;
      int pulses, t, w, lat;
      send_req(2'd1, ok);
      pll_lock = 1'b0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL fail_accept: got not-accepted want accepted"); end
      pulses = 0; prev = 1'b0; t = 0;
      while (!error && t < LIMIT) begin
         if (pll_reset && !prev) pulses++;
         prev = pll_reset;
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (pulses != int'(MAX_RETRIES + 1)) begin
         n_fail++; $display("FAIL fail_pulses: got %0d want %0d", pulses, MAX_RETRIES + 1);
      end
      n_checks++;
      if (t != int'((MAX_RETRIES + 1) * (RESET_CYCLES + LOCK_TIMEOUT))) begin
         n_fail++; $display("FAIL fail_time: got %0d want %0d", t, (MAX_RETRIES + 1) * (RESET_CYCLES + LOCK_TIMEOUT));
      end
      n_checks++;
      if ({error, mode_req_ready, pixel_rstn, pll_reset, ready} !== 5'b11000) begin
         n_fail++; $display("FAIL fail_flags: got %b want 11000", {error, mode_req_ready, pixel_rstn, pll_reset, ready});
      end
      send_req(2'd2, ok);
      n_checks++;
      if (!ok || error !== 1'b0 || pll_reset !== 1'b1 || cur_mode !== 2'd2 ||
          {pll_idsel, pll_fbdsel, pll_odsel} !== exp_codes(2)) begin
         n_fail++; $display("FAIL recover_accept: ok %0d err %b rst %b mode %0d div %h want 1 0 1 2 %h",
            ok, error, pll_reset, cur_mode, {pll_idsel, pll_fbdsel, pll_odsel}, exp_codes(2));
      end
      rst_width(w);
      lock_after(40, lat);
      n_checks++;
      if (w != int'(RESET_CYCLES) || lat != READY_LAT || error !== 1'b0) begin
         n_fail++; $display("FAIL recover_ready: width %0d lat %0d err %b want %0d %0d 0", w, lat, error, RESET_CYCLES, READY_LAT);
      end
      model_mode = 2;
   endtask

   task automatic test_glitch();
      bit ok;
      int w, g, early, lat;
      send_req(2'd0, ok);
      pll_lock = 1'b0;
      rst_width(w);
      repeat (50) @(negedge clk);
      pll_lock = 1'b1;
      g = int'($urandom_range(200, 600));
      early = 0;
      repeat (g) begin
         @(negedge clk);
         if (ready) early++;
      end
      pll_lock = 1'b0;
      @(negedge clk);
      if (ready) early++;
      pll_lock = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ready && lat < LIMIT);
      n_checks++;
      if (!ok || early != 0) begin
         n_fail++; $display("FAIL glitch_early_ready: ok %0d early %0d want 1 0", ok, early);
      end
      n_checks++;
      if (lat != READY_LAT) begin
         n_fail++; $display("FAIL glitch_restart: got %0d want %0d after re-lock", lat, READY_LAT);
      end
      model_mode = 0;
   endtask

   task automatic test_lock_loss();
      int lat, rst_hi;
      pll_lock = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (pixel_rstn && lat < 10);
      n_checks++;
      if (pixel_rstn !== 1'b0 || ready !== 1'b0 || lat > 3) begin
         n_fail++; $display("FAIL loss_latency: cycles %0d rstn %b ready %b want <=3 0 0", lat, pixel_rstn, ready);
      end
      rst_hi = 0;
      repeat (60) begin
         if (pll_reset) rst_hi++;
         @(negedge clk);
      end
      n_checks++;
      if (rst_hi != 0) begin
         n_fail++; $display("FAIL loss_no_pll_reset: got %0d high cycles want 0", rst_hi);
      end
      lock_after(1, lat);
      n_checks++;
      if (lat != READY_LAT || cur_mode !== 2'(model_mode)) begin
         n_fail++; $display("FAIL loss_relock: lat %0d mode %0d want %0d %0d", lat, cur_mode, READY_LAT, model_mode);
      end
   endtask

   task automatic test_same_and_bad();
      bit ok;
      int rst_hi;
      send_req(2'(model_mode), ok);
      n_checks++;
      if (!ok || {pll_reset, ready, pixel_rstn, bad_mode} !== 4'b0110) begin
         n_fail++; $display("FAIL same_mode_noop: ok %0d flags %b want 1 0110", ok, {pll_reset, ready, pixel_rstn, bad_mode});
      end
      rst_hi = 0;
      repeat (20) begin
         @(negedge clk);
         if (pll_reset || !ready) rst_hi++;
      end
      n_checks++;
      if (rst_hi != 0) begin
         n_fail++; $display("FAIL same_mode_stable: got %0d disturbed cycles want 0", rst_hi);
      end
      send_req(2'd3, ok);
      n_checks++;
      if (!ok || {bad_mode, ready, pll_reset} !== 3'b110 || cur_mode !== 2'(model_mode) ||
          {pll_idsel, pll_fbdsel, pll_odsel} !== exp_codes(model_mode)) begin
         n_fail++; $display("FAIL bad_mode_pulse: ok %0d flags %b mode %0d div %h want 1 110 %0d %h",
            ok, {bad_mode, ready, pll_reset}, cur_mode, {pll_idsel, pll_fbdsel, pll_odsel}, model_mode, exp_codes(model_mode));
      end
      @(negedge clk);
      n_checks++;
      if (bad_mode !== 1'b0) begin
         n_fail++; $display("FAIL bad_mode_width: got %b want 0", bad_mode);
      end
   endtask

   task automatic test_random();
      bit ok;
      int w, lat, d;
      logic [1:0] m;
      for (int i = 0; i < 8; i++) begin
         m = 2'($urandom_range(0, 3));
         d = int'($urandom_range(1, 300));
         send_req(m, ok);
         n_checks++;
         if (!ok) begin
            n_fail++; $display("FAIL rand_accept[%0d]: got not-accepted want accepted", i);
         end else if (int'(m) >= int'(NUM_MODES)) begin
            if ({bad_mode, ready, pll_reset} !== 3'b110 || cur_mode !== 2'(model_mode)) begin
               n_fail++; $display("FAIL rand_bad[%0d]: flags %b mode %0d want 110 %0d", i, {bad_mode, ready, pll_reset}, cur_mode, model_mode);
            end
         end else if (int'(m) == model_mode) begin
            if ({bad_mode, ready, pll_reset} !== 3'b010) begin
               n_fail++; $display("FAIL rand_same[%0d]: flags %b want 010", i, {bad_mode, ready, pll_reset});
            end
         end else begin
            if ({pll_reset, ready} !== 2'b10 || cur_mode !== m || {pll_idsel, pll_fbdsel, pll_odsel} !== exp_codes(int'(m))) begin
               n_fail++; $display("FAIL rand_change[%0d]: flags %b mode %0d div %h want 10 %0d %h",
                  i, {pll_reset, ready}, cur_mode, {pll_idsel, pll_fbdsel, pll_odsel}, m, exp_codes(int'(m)));
            end
            pll_lock = 1'b0;
            rst_width(w);
            lock_after(d, lat);
            n_checks++;
            if (w != int'(RESET_CYCLES) || lat != READY_LAT) begin
               n_fail++; $display("FAIL rand_seq[%0d]: width %0d lat %0d want %0d %0d", i, w, lat, RESET_CYCLES, READY_LAT);
            end
            model_mode = int'(m);
         end
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      int w, lat;
      send_req((model_mode == 0) ? 2'd2 : 2'd0, ok);
      pll_lock = 1'b0;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({pll_reset, pixel_rstn, ready, error, bad_mode, mode_req_ready} !== 6'b100000 ||
          cur_mode !== 2'(BOOT_MODE) || {pll_idsel, pll_fbdsel, pll_odsel} !== exp_codes(int'(BOOT_MODE))) begin
         n_fail++; $display("FAIL mid_reset_values: flags %b mode %0d div %h want 100000 %0d %h",
            {pll_reset, pixel_rstn, ready, error, bad_mode, mode_req_ready}, cur_mode,
            {pll_idsel, pll_fbdsel, pll_odsel}, BOOT_MODE, exp_codes(int'(BOOT_MODE)));
      end
      resetn = 1'b1;
      rst_width(w);
      lock_after(20, lat);
      n_checks++;
      if (!ok || w != int'(RESET_CYCLES) || lat != READY_LAT) begin
         n_fail++; $display("FAIL mid_reset_rebuild: ok %0d width %0d lat %0d want 1 %0d %0d", ok, w, lat, RESET_CYCLES, READY_LAT);
      end
      model_mode = int'(BOOT_MODE);
   endtask

   initial begin
      test_reset();
      test_mode_change();
      test_fail_recover();
      test_glitch();
      test_lock_loss();
      test_same_and_bad();
      test_random();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
